// File: rtl/md5_pkg.sv
// md5_pkg
// Shared constants, state type and padding helper for the MD5 candidate
// matcher slice.
//   MD5_BLK_W / MD5_DIG_W : message block and digest widths
//   MD5_PAD_WORD          : word 1 of a 4-byte message (0x80 terminator byte)
//   MD5_LEN32             : word 14, the message length in bits (32)
//   md5_state_e           : matcher state (SEARCH / HIT)
//   md5_pad_block()       : builds the single padded block for one candidate
package md5_pkg;

  localparam int          MD5_BLK_W    = 512;
  localparam int          MD5_DIG_W    = 128;
  localparam logic [31:0] MD5_PAD_WORD = 32'h0000_0080;
  localparam logic [31:0] MD5_LEN32    = 32'h0000_0020;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    HIT    = 1'b1
  } md5_state_e;

  // Words are little-endian: word k lives in bits [32k+31:32k].
  function automatic logic [MD5_BLK_W-1:0] md5_pad_block(input logic [31:0] cand);
    logic [MD5_BLK_W-1:0] blk;
    blk            = '0;
    blk[31:0]      = cand;
    blk[63:32]     = MD5_PAD_WORD;
    blk[479:448]   = MD5_LEN32;
    return blk;
  endfunction

endpackage

// File: rtl/md5_tag_delay.sv
// md5_tag_delay
// Valid+data shift register that carries each candidate alongside the
// fixed-latency MD5 core so the tag appears in the same cycle as its digest.
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset; empties every stage
//   i_valid  : tag valid entering the line
//   i_data   : tag (candidate) entering the line
//   o_valid  : tag valid leaving the line, DEPTH cycles later
//   o_data   : tag leaving the line
module md5_tag_delay #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid[0] <= 1'b0;
      r_data[0]  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
        end else begin
          r_valid[gi] <= r_valid[gi-1];
          r_data[gi]  <= r_data[gi-1];
        end
      end
    end
  endgenerate

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/md5_candidate_matcher.sv
// md5_candidate_matcher
// Pads each 32-bit candidate into an MD5 block, tracks it through the core
// latency, compares the returned digest with the target and latches the
// first match (raising halt to stop the candidate counter).
//   CLK          : clock, rising edge
//   reset        : asynchronous active-high reset
//   clear        : synchronous clear of found / sync_err / checked
//   target       : digest being searched for
//   cand_in      : candidate value, cand_valid qualifies it
//   blk_out      : padded block to the MD5 core, blk_valid qualifies it
//   digest_in    : digest from the core, digest_valid qualifies it
//   halt, found  : a match is latched
//   found_cand   : candidate of the first match
//   checked      : saturating count of compared digests
//   sync_err     : sticky, core output and tag line disagreed
module md5_candidate_matcher
  import md5_pkg::*;
#(
  parameter int PIPE_LAT = 64
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [MD5_DIG_W-1:0] target,
  input  logic [31:0]          cand_in,
  input  logic                 cand_valid,
  output logic [MD5_BLK_W-1:0] blk_out,
  output logic                 blk_valid,
  input  logic [MD5_DIG_W-1:0] digest_in,
  input  logic                 digest_valid,
  output logic                 halt,
  output logic                 found,
  output logic [31:0]          found_cand,
  output logic [31:0]          checked,
  output logic                 sync_err
);

  logic [MD5_BLK_W-1:0] r_blk_out;
  logic                 r_blk_valid;
  md5_state_e           r_state;
  logic [31:0]          r_found_cand;
  logic [31:0]          r_checked;
  logic                 r_sync_err;

  logic                 w_tag_valid;
  logic [31:0]          w_tag_cand;
  logic                 w_cmp;
  logic                 w_hit;
  logic                 w_misalign;
  logic [31:0]          w_checked_inc;

  // Block register: one padded block per accepted candidate, no back-pressure.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_blk_out   <= '0;
      r_blk_valid <= 1'b0;
    end else begin
      r_blk_out   <= md5_pad_block(cand_in);
      r_blk_valid <= cand_valid;
    end
  end

  // Tag line is fed from the registered block so it lines up with the
  // core's own PIPE_LAT-cycle latency measured from blk_valid.
  md5_tag_delay #(
    .DEPTH  (PIPE_LAT),
    .DATA_W (32)
  ) u_tag_delay (
    .i_clk   (CLK),
    .i_rst   (reset),
    .i_valid (r_blk_valid),
    .i_data  (r_blk_out[31:0]),
    .o_valid (w_tag_valid),
    .o_data  (w_tag_cand)
  );

  assign w_cmp         = w_tag_valid & digest_valid;
  assign w_hit         = w_cmp & (digest_in == target);
  assign w_misalign    = w_tag_valid ^ digest_valid;
  assign w_checked_inc = (r_checked == 32'hFFFF_FFFF) ? r_checked : r_checked + 32'd1;

  // Later assignments override earlier ones, so an event in the same cycle
  // as clear is applied on top of the cleared state (hit wins over clear).
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_found_cand <= '0;
      r_checked    <= '0;
      r_sync_err   <= 1'b0;
    end else begin
      if (clear) begin
        r_state      <= SEARCH;
        r_found_cand <= '0;
        r_checked    <= '0;
        r_sync_err   <= 1'b0;
      end
      if (w_misalign) begin
        r_sync_err <= 1'b1;
      end
      if (w_cmp) begin
        r_checked <= clear ? 32'd1 : w_checked_inc;
      end
      // First match wins: in HIT only a simultaneous clear re-arms capture.
      if (w_hit && (clear || (r_state == SEARCH))) begin
        r_state      <= HIT;
        r_found_cand <= w_tag_cand;
      end
    end
  end

  assign blk_out    = r_blk_out;
  assign blk_valid  = r_blk_valid;
  assign found      = (r_state == HIT);
  assign halt       = (r_state == HIT);
  assign found_cand = r_found_cand;
  assign checked    = r_checked;
  assign sync_err   = r_sync_err;

endmodule

// File: doc/md5_candidate_matcher.md
# md5_candidate_matcher

Downstream neighbour of the candidate counter in the MD5 brute-force datapath. Takes each 32-bit candidate, builds the padded single-block MD5 message for the fixed-latency MD5 core, and tracks the candidate alongside the core pipeline. Compares each returned digest with the target, latches the first matching candidate and raises `halt`, which gates the counter's enable. Also counts checked candidates and flags any loss of core/tag alignment.

## Interface
- `PIPE_LAT`, default 64: MD5 core latency in cycles, from `blk_valid` to `digest_valid`; must be ≥1.
- `CLK`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `clear`  in  1: synchronous; clears found/error state and `checked`.
- `target`  in  128: digest to find; held stable while running.
- `cand_in`  in  32: candidate value, the counter's `count`.
- `cand_valid`  in  1: `cand_in` is a new candidate this cycle.
- `blk_out`  out  512: padded message block to the MD5 core.
- `blk_valid`  out  1: `blk_out` valid this cycle.
- `digest_in`  in  128: digest from the MD5 core.
- `digest_valid`  in  1: `digest_in` valid this cycle.
- `halt`  out  1: a match is latched; upstream deasserts the counter enable.
- `found`  out  1: a match is latched.
- `found_cand`  out  32: candidate whose digest matched.
- `checked`  out  32: number of digests compared; saturates at 0xFFFFFFFF.
- `sync_err`  out  1: sticky; core output and tag line disagreed.

## Operation
- Padding, with words little-endian as MD5 expects:
  - `blk_out[31:0]` = `cand_in`.
  - `[63:32]` = 0x00000080.
  - Words 2–13 = 0.
  - `[479:448]` = 0x00000020 (message length, 32 bits).
  - `[511:480]` = 0.
- `blk_out`/`blk_valid` are registered from `cand_in`/`cand_valid`. The block never back-pressures.
- Tag line: a `PIPE_LAT`-stage shift register of {valid, candidate} fed from {`blk_valid`, `blk_out[31:0]`}. Its output aligns with `digest_valid`.
- Each cycle, at the tag line output:
  - Tag valid and `digest_valid`: compare `digest_in` with `target` and increment `checked`.
  - Tag valid XOR `digest_valid`: set `sync_err`; no compare.
- State machine:
  - SEARCH: `found`=0. A compare hit latches the tag candidate into `found_cand` and moves to HIT.
  - HIT: `found`=`halt`=1. Later hits are ignored (first match wins). In-flight digests are still compared and counted. `clear` returns to SEARCH.
- `sync_err` does not change state. It clears only on `reset` or `clear`.
- `clear` and a hit in the same cycle: the hit wins. The state is HIT with the new `found_cand`, and `checked` = 1.
- Candidate 0xFFFFFFFF is processed normally. There is no wrap handling; the counter stops itself.
- `checked` holds at 0xFFFFFFFF once reached.

## Timing
- Reset values: `blk_out`=0, `blk_valid`=0, tag line all invalid, `found`=0, `halt`=0, `found_cand`=0, `checked`=0, `sync_err`=0, state SEARCH.
- `cand_valid` at cycle t → `blk_valid` at t+1 → `digest_valid` expected at t+1+`PIPE_LAT`.
- `found`/`halt`/`checked`/`sync_err` update one cycle after the digest cycle, i.e. at t+2+`PIPE_LAT`.
- After `halt` rises, up to `PIPE_LAT`+2 further candidates may already be in flight. They are checked but never replace `found_cand`.
- Back-to-back candidates at one per cycle are fully supported.
- `reset` mid-run flushes the tag line immediately. The MD5 core shares `reset`, so no stale digests are expected; any that arrive set `sync_err`.

## Structure
- Shared package `md5_pkg`: `MD5_BLK_W`=512, `MD5_DIG_W`=128, `MD5_PAD_WORD`=32'h00000080, `MD5_LEN32`=32'h00000020, and the state enum {SEARCH, HIT}.
- Sub-module `md5_tag_delay`: parameterised valid+data shift register of depth `PIPE_LAT`, asynchronous reset.
- Padding, compare, FSM and counters stay in the top level.

## Test plan
- `PIPE_LAT`=4, candidate 0x00000000 → `blk_out` word0=0, word1=0x80, word14=0x20, all other words 0; `blk_valid` one cycle after `cand_valid`.
- Model core returns `target` for candidate 0x1234 in a stream 0x1230..0x1240 → `found`=1 and `found_cand`=0x1234 at the required cycle; `checked` ends at 17.
- Two hits (0x10 then 0x12) → `found_cand` stays 0x10; `halt` stays high until `clear`.
- Drop one `digest_valid` from the model → `sync_err`=1 and sticky; `clear` → 0.
- Assert `reset` with 3 candidates in flight → all outputs at reset values immediately; the next candidate is processed normally.
- Same-cycle `clear` and hit on 0xFFFFFFFF → HIT, `found_cand`=0xFFFFFFFF, `checked`=1.
